wb_stage: RTL and testbench

MEM/WB pipeline register and writeback controller for the pipelined MIPS core. It captures each instruction result leaving the MEM stage and selects the writeback value (ALU result, load data or link address). It drives the register file write port (`regwrite`, `write_reg`, `write_data`), which commits on the same `posedge clk`, and exposes a bypass copy of that write to the forwarding unit. It also keeps a retired-instruction counter.

---
 rtl/mips_pkg.sv | 40 ++++
 rtl/wb_select.sv | 34 +++
 rtl/wb_stage.sv | 113 +++++++++++
 tb/tb_wb_stage.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg
// Shared definitions for the pipelined MIPS core: datapath widths, the
// hard-wired zero register index, the writeback select encoding, the
// MEM/WB bundle layout, and a helper that turns the MEM-stage control bits
// into a writeback select.
package mips_pkg;

   localparam int DATA_W = 32;
   localparam int REG_W  = 5;
   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef enum logic [1:0] {
      WB_ALU  = 2'd0,
      WB_MEM  = 2'd1,
      WB_LINK = 2'd2
   } wb_sel_t;

   typedef struct packed {
      logic                     v;
      logic                     rw;
      wb_sel_t                  sel;
      logic [REG_W-1:0]         dst;
      logic signed [DATA_W-1:0] alu;
      logic signed [DATA_W-1:0] rdata;
      logic [DATA_W-1:0]        pc4;
      logic                     done;
   } memwb_t;

   // Link (jal/jalr) takes precedence over a load so the return address
   // always lands in the destination register.
   function automatic wb_sel_t sel_encode(input logic link, input logic memtoreg);
      if (link)
         return WB_LINK;
      else if (memtoreg)
         return WB_MEM;
      else
         return WB_ALU;
   endfunction

endpackage

// File: rtl/wb_select.sv
// wb_select
// Combinational 3:1 writeback mux. Shared between the writeback stage and
// the forwarding unit so both see exactly the same selected value.
// Ports:
//   sel   - writeback source (ALU result, load data, link address)
//   alu   - ALU result
//   rdata - data-memory read data
//   pc4   - PC+4 of the instruction
//   y     - selected value, a straight copy with no extension
module wb_select
   import mips_pkg::*;
#(
   parameter int W = 32
) (
   input  wb_sel_t            sel,
   input  logic signed [W-1:0] alu,
   input  logic signed [W-1:0] rdata,
   input  logic [W-1:0]       pc4,
   output logic signed [W-1:0] y
);

   // The unused encoding falls back to the ALU result so the mux never
   // produces an unknown value.
   always_comb begin
      y = alu;
      case (sel)
         WB_ALU:  y = alu;
         WB_MEM:  y = rdata;
         WB_LINK: y = pc4;
         default: y = alu;
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// wb_stage
// MEM/WB pipeline register and writeback controller. Captures each result
// leaving MEM, selects the writeback value, drives the register-file write
// port, mirrors that write to the forwarding unit and counts retirements.
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   mem_valid/regwrite/memtoreg/link/dst/alu/rdata/pc4
//                                 - instruction leaving the MEM stage
//   stall                         - hold the current entry
//   flush                         - replace the current entry with a bubble
//   regwrite, write_reg, write_data
//                                 - register-file write port
//   fwd_valid, fwd_reg, fwd_data  - forwarding copy of the current write
//   retired                       - retired valid instruction count
module wb_stage #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5,
   parameter int CNT_W  = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     mem_valid,
   input  logic                     mem_regwrite,
   input  logic                     mem_memtoreg,
   input  logic                     mem_link,
   input  logic [REG_W-1:0]         mem_dst,
   input  logic signed [DATA_W-1:0] mem_alu,
   input  logic signed [DATA_W-1:0] mem_rdata,
   input  logic [DATA_W-1:0]        mem_pc4,
   input  logic                     stall,
   input  logic                     flush,
   output logic                     regwrite,
   output logic [REG_W-1:0]         write_reg,
   output logic signed [DATA_W-1:0] write_data,
   output logic                     fwd_valid,
   output logic [REG_W-1:0]         fwd_reg,
   output logic signed [DATA_W-1:0] fwd_data,
   output logic [CNT_W-1:0]         retired
);

   import mips_pkg::*;

   logic                     v_q;
   logic                     rw_q;
   wb_sel_t                  sel_q;
   logic [REG_W-1:0]         dst_q;
   logic signed [DATA_W-1:0] alu_q;
   logic signed [DATA_W-1:0] rdata_q;
   logic [DATA_W-1:0]        pc4_q;
   logic                     done_q;
   logic signed [DATA_W-1:0] wb_value;
   logic                     writes_reg;

   // Stage register plus retire counter. An entry retires on the edge that
   // ends its first live cycle, which is the same edge the register file
   // commits it; afterwards 'done' marks it so a stall cannot retire or
   // write it again. The counter is independent of flush/stall because
   // whatever was live during this cycle has already been committed.
   always_ff @(posedge clk) begin
      if (rst) begin
         v_q     <= 1'b0;
         rw_q    <= 1'b0;
         sel_q   <= WB_ALU;
         dst_q   <= '0;
         alu_q   <= '0;
         rdata_q <= '0;
         pc4_q   <= '0;
         done_q  <= 1'b0;
         retired <= '0;
      end else begin
         if (v_q && !done_q)
            retired <= retired + CNT_W'(1);

         if (flush) begin
            v_q    <= 1'b0;
            done_q <= 1'b0;
         end else if (stall) begin
            if (v_q)
               done_q <= 1'b1;
         end else begin
            v_q     <= mem_valid;
            rw_q    <= mem_regwrite;
            sel_q   <= sel_encode(mem_link, mem_memtoreg);
            dst_q   <= mem_dst;
            alu_q   <= mem_alu;
            rdata_q <= mem_rdata;
            pc4_q   <= mem_pc4;
            done_q  <= 1'b0;
         end
      end
   end

   wb_select #(
      .W(DATA_W)
   ) u_wb_select (
      .sel   (sel_q),
      .alu   (alu_q),
      .rdata (rdata_q),
      .pc4   (pc4_q),
      .y     (wb_value)
   );

   // $0 is hard-wired, so writes to it are never committed nor forwarded.
   // Forwarding ignores 'done': a held entry is still the youngest value.
   assign writes_reg = v_q & rw_q & (dst_q != REG_W'(REG_ZERO));
   assign regwrite   = writes_reg & ~done_q;
   assign write_reg  = dst_q;
   assign write_data = wb_value;
   assign fwd_valid  = writes_reg;
   assign fwd_reg    = dst_q;
   assign fwd_data   = wb_value;

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage
// Scoreboard bench for wb_stage (retire counter narrowed to 4 bits so the
// wrap is reachable). Each directed vector pushes its hand-computed
// expected outputs for the following cycle; a monitor pops and compares
// on the falling edge.
module tb_wb_stage;

   logic        clk;
   logic        rst;
   logic        mem_valid;
   logic        mem_regwrite;
   logic        mem_memtoreg;
   logic        mem_link;
   logic [4:0]  mem_dst;
   logic [31:0] mem_alu;
   logic [31:0] mem_rdata;
   logic [31:0] mem_pc4;
   logic        stall;
   logic        flush;
   logic        regwrite;
   logic [4:0]  write_reg;
   logic [31:0] write_data;
   logic        fwd_valid;
   logic [4:0]  fwd_reg;
   logic [31:0] fwd_data;
   logic [3:0]  retired;

   typedef struct {
      int          due;
      logic        rw;
      logic [4:0]  wreg;
      logic [31:0] data;
      logic        fwd;
      logic [3:0]  ret;
      logic        chk;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   wb_stage #(
      .DATA_W(32),
      .REG_W (5),
      .CNT_W (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .mem_valid    (mem_valid),
      .mem_regwrite (mem_regwrite),
      .mem_memtoreg (mem_memtoreg),
      .mem_link     (mem_link),
      .mem_dst      (mem_dst),
      .mem_alu      (mem_alu),
      .mem_rdata    (mem_rdata),
      .mem_pc4      (mem_pc4),
      .stall        (stall),
      .flush        (flush),
      .regwrite     (regwrite),
      .write_reg    (write_reg),
      .write_data   (write_data),
      .fwd_valid    (fwd_valid),
      .fwd_reg      (fwd_reg),
      .fwd_data     (fwd_data),
      .retired      (retired)
   );

   // Free-running clock, first rising edge at 5.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Cycle index advances on every rising edge; expectations are tagged
   // with the cycle in which they must be visible.
   always @(posedge clk) cyc++;

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s cycle %0d: got 0x%0h expected 0x%0h",
                  name, cyc, act, exp);
      end
   endtask

   // Monitor: pops every expectation due this cycle and compares it with
   // the outputs sampled mid-cycle. Register/data fields are skipped when
   // the entry is a flushed bubble whose payload is don't-care.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         mon_e = sb.pop_front();
         if (mon_e.due < cyc) begin
            checkOutput("late_expectation", cyc, mon_e.due);
         end else begin
            checkOutput("regwrite", regwrite, mon_e.rw);
            checkOutput("fwd_valid", fwd_valid, mon_e.fwd);
            checkOutput("retired", retired, mon_e.ret);
            if (mon_e.chk) begin
               checkOutput("write_reg", write_reg, mon_e.wreg);
               checkOutput("write_data", write_data, mon_e.data);
               checkOutput("fwd_reg", fwd_reg, mon_e.wreg);
               checkOutput("fwd_data", fwd_data, mon_e.data);
            end
         end
      end
   end

   // Drive one cycle of inputs and queue what the outputs must show in the
   // cycle after the next rising edge.
   task automatic applyStimulus(
      input logic rs, input logic st, input logic fl,
      input logic vld, input logic rw, input logic m2r, input logic lnk,
      input logic [4:0] dst, input logic [31:0] alu,
      input logic [31:0] rdata, input logic [31:0] pc4,
      input logic e_rw, input logic [4:0] e_reg, input logic [31:0] e_data,
      input logic e_fwd, input logic [3:0] e_ret, input logic e_chk);
      exp_t e;
      rst          = rs;
      stall        = st;
      flush        = fl;
      mem_valid    = vld;
      mem_regwrite = rw;
      mem_memtoreg = m2r;
      mem_link     = lnk;
      mem_dst      = dst;
      mem_alu      = alu;
      mem_rdata    = rdata;
      mem_pc4      = pc4;
      e.due  = cyc + 1;
      e.rw   = e_rw;
      e.wreg = e_reg;
      e.data = e_data;
      e.fwd  = e_fwd;
      e.ret  = e_ret;
      e.chk  = e_chk;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   initial begin
      //             rs st fl  v rw m2r lk dst  alu          rdata        pc4         e_rw reg  data          fwd ret chk
      // Reset state
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 5'd0,  32'h0,       32'h0,       32'h0,      0, 5'd0,  32'h0,        0, 4'd0, 1);
      applyStimulus(1, 0, 0, 1, 1, 0, 0, 5'd6,  32'h11,      32'h0,       32'h0,      0, 5'd0,  32'h0,        0, 4'd0, 1);
      // ALU write to r8
      applyStimulus(0, 0, 0, 1, 1, 0, 0, 5'd8,  32'h9,       32'h0,       32'h0,      1, 5'd8,  32'h9,        1, 4'd0, 1);
      // Load of -5 into r12, ALU value must not leak through
      applyStimulus(0, 0, 0, 1, 1, 1, 0, 5'd12, 32'd100,     32'hFFFF_FFFB, 32'h0,    1, 5'd12, 32'hFFFF_FFFB, 1, 4'd1, 1);
      // Link overrides memtoreg
      applyStimulus(0, 0, 0, 1, 1, 1, 1, 5'd31, 32'h5,       32'h6,       32'h40,     1, 5'd31, 32'h40,       1, 4'd2, 1);
      // Write to $0: suppressed but still retires
      applyStimulus(0, 0, 0, 1, 1, 0, 0, 5'd0,  32'h7,       32'h0,       32'h0,      0, 5'd0,  32'h7,        0, 4'd3, 1);
      // Non-writing instruction (store)
      applyStimulus(0, 0, 0, 1, 0, 0, 0, 5'd5,  32'h1234,    32'h0,       32'h0,      0, 5'd5,  32'h1234,     0, 4'd4, 1);
      // Bubble with write bits set: nothing written, forwarded or retired
      applyStimulus(0, 0, 0, 0, 1, 0, 0, 5'd3,  32'hAA,      32'h0,       32'h0,      0, 5'd3,  32'hAA,       0, 4'd5, 1);
      // r17 write then stalled 3 cycles with garbage on the MEM side
      applyStimulus(0, 0, 0, 1, 1, 0, 0, 5'd17, 32'h55,      32'h0,       32'h0,      1, 5'd17, 32'h55,       1, 4'd5, 1);
      applyStimulus(0, 1, 0, 1, 1, 0, 0, 5'd2,  32'h99,      32'h0,       32'h0,      0, 5'd17, 32'h55,       1, 4'd6, 1);
      applyStimulus(0, 1, 0, 1, 1, 0, 0, 5'd2,  32'h99,      32'h0,       32'h0,      0, 5'd17, 32'h55,       1, 4'd6, 1);
      applyStimulus(0, 1, 0, 1, 1, 0, 0, 5'd2,  32'h99,      32'h0,       32'h0,      0, 5'd17, 32'h55,       1, 4'd6, 1);
      // Already-retired entry hit by flush+stall: bubble, counter frozen
      applyStimulus(0, 0, 0, 1, 1, 0, 0, 5'd20, 32'h77,      32'h0,       32'h0,      1, 5'd20, 32'h77,       1, 4'd6, 1);
      applyStimulus(0, 1, 0, 1, 1, 0, 0, 5'd21, 32'h78,      32'h0,       32'h0,      0, 5'd20, 32'h77,       1, 4'd7, 1);
      applyStimulus(0, 1, 1, 1, 1, 0, 0, 5'd22, 32'h79,      32'h0,       32'h0,      0, 5'd0,  32'h0,        0, 4'd7, 0);
      // Stalled bubble stays a bubble
      applyStimulus(0, 1, 0, 1, 1, 0, 0, 5'd23, 32'h7A,      32'h0,       32'h0,      0, 5'd0,  32'h0,        0, 4'd7, 0);
      // Fresh valid entry flushed: it still commits on the flush edge
      applyStimulus(0, 0, 0, 1, 1, 0, 0, 5'd10, 32'h3C,      32'h0,       32'h0,      1, 5'd10, 32'h3C,       1, 4'd7, 1);
      applyStimulus(0, 0, 1, 1, 1, 0, 0, 5'd11, 32'h3D,      32'h0,       32'h0,      0, 5'd0,  32'h0,        0, 4'd8, 0);
      // r9 write pending when reset arrives
      applyStimulus(0, 0, 0, 1, 1, 0, 0, 5'd9,  32'h33,      32'h0,       32'h0,      1, 5'd9,  32'h33,       1, 4'd8, 1);
      applyStimulus(1, 0, 0, 1, 1, 0, 0, 5'd4,  32'h44,      32'h0,       32'h0,      0, 5'd0,  32'h0,        0, 4'd0, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 5'd0,  32'h0,       32'h0,       32'h0,      0, 5'd0,  32'h0,        0, 4'd0, 1);
      // 17 back-to-back retires through a 4-bit counter
      for (int i = 0; i < 17; i++) begin
         applyStimulus(0, 0, 0, 1, 1, 0, 0, 5'(i + 1), 32'(i + 32'h100), 32'h0, 32'h0,
                       1, 5'(i + 1), 32'(i + 32'h100), 1, 4'(i), 1);
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 5'd0,  32'h0,       32'h0,       32'h0,      0, 5'd0,  32'h0,        0, 4'd1, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 5'd0,  32'h0,       32'h0,       32'h0,      0, 5'd0,  32'h0,        0, 4'd1, 1);

      // Let the monitor drain within a fixed budget.
      repeat (3) @(posedge clk);
      checkOutput("scoreboard_drain", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
